scan_test_sequencer: RTL
========================

Name: scan_test_sequencer

Overview:
- Drives one scan chain built from reset-able mux-D scan flip-flops (SE/SI/RESET/CK cells) and consumes its scan output.
- Per test pattern: shift in a stimulus, pulse one capture clock, shift out the response, and compare it against an expected vector.
- Flags mismatches and keeps a saturating error count.
- Serves as the on-chip pattern applicator for fault-injection validation runs.

Parameters:
- CHAIN_LEN, 8, number of scan cells in the chain (≥2).
- CNT_W, 8, width of the error counter.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RESETN  input  1  asynchronous active-low reset.
- START  input  1  request to apply one pattern; sampled only in IDLE.
- PAT_IN  input  CHAIN_LEN  stimulus vector; latched on accepted START.
- EXP_IN  input  CHAIN_LEN  expected response; latched on accepted START.
- SO  input  1  scan output of the last chain cell.
- SE  output  1  scan enable to every chain cell.
- SI  output  1  scan input to the first chain cell.
- BUSY  output  1  high from the cycle after an accepted START through the DONE cycle.
- DONE  output  1  one-cycle pulse when the result is valid.
- RESP_OUT  output  CHAIN_LEN  captured response; held until the next accepted START.
- MISMATCH  output  1  RESP_OUT != expected; held like RESP_OUT.
- ERR_CNT  output  CNT_W  saturating count of mismatching patterns.

Behaviour:
- Reset (RESETN=0, async): state=IDLE; SE=0, SI=0, BUSY=0, DONE=0, RESP_OUT=0, MISMATCH=0, ERR_CNT=0; internal registers and counters cleared. Reset is honoured in any state; a pattern in progress is discarded, with no DONE and no count update.
- All outputs are registered.
- States: IDLE, LOAD, CAPTURE, UNLOAD, FINISH.
- IDLE:
  - START=1 at an edge latches PAT_IN into pat_sr and EXP_IN into exp_r, clears bit_cnt, and goes to LOAD.
  - MISMATCH is cleared and RESP_OUT is zeroed on acceptance.
  - In any other state, START is ignored.
- LOAD:
  - SE=1, SI=pat_sr[CHAIN_LEN-1] (MSB first); pat_sr shifts left each cycle.
  - Lasts exactly CHAIN_LEN cycles, then CAPTURE.
  - After LOAD, the cell nearest SO holds PAT[CHAIN_LEN-1].
- CAPTURE: exactly one cycle, SE=0, SI=0; the chain loads functional D. Then UNLOAD.
- UNLOAD:
  - SE=1, SI=0, for CHAIN_LEN cycles.
  - At each edge in UNLOAD, SO is sampled before the chain shifts on that same edge: resp_sr <= {resp_sr[CHAIN_LEN-2:0], SO}.
  - After the last sample, resp_sr[CHAIN_LEN-1] is the cell nearest SO, in the same bit ordering as PAT_IN.
  - Then FINISH.
- FINISH:
  - Exactly one cycle: DONE=1, SE=0, RESP_OUT=resp_sr, MISMATCH=(resp_sr != exp_r).
  - If mismatched, ERR_CNT increments, saturating at 2^CNT_W-1.
  - Next state is IDLE.
- Latency: from the accepted-START edge to the DONE cycle is 2*CHAIN_LEN+2 edges (LOAD N, CAPTURE 1, UNLOAD N, FINISH 1). BUSY is high for that whole interval.
- A START present in the FINISH cycle is ignored. A START held high into IDLE starts a new pattern at the next edge (back-to-back allowed; one idle cycle minimum).
- bit_cnt width is clog2(CHAIN_LEN); it wraps to 0 on each LOAD→CAPTURE and UNLOAD→FINISH transition.
- ERR_CNT clears only on reset.

Test Plan:
- CHAIN_LEN=8, identity chain model (capture D=Q), PAT_IN=8'hA5, EXP_IN=8'hA5, START one cycle:
  - SI sequence 1,0,1,0,0,1,0,1; SE high 8 cycles, low 1, high 8.
  - DONE at edge 18 after START; RESP_OUT=8'hA5, MISMATCH=0, ERR_CNT=0.
- Inverting chain model (capture D=~Q), PAT_IN=8'h0F, EXP_IN=8'hF0 → RESP_OUT=8'hF0, MISMATCH=0. Repeat with EXP_IN=8'hF1 → MISMATCH=1, ERR_CNT=1.
- CNT_W=2, five consecutive mismatching patterns → ERR_CNT sequence 1,2,3,3,3; no wrap to 0.
- START pulsed during LOAD and again during UNLOAD → ignored; exactly one DONE; latency still 18.
- RESETN dropped at the 4th LOAD cycle → SE, BUSY, and all outputs 0 immediately (async), with no DONE. After release, a new START with 8'h3C completes normally with RESP_OUT=8'h3C.
- START held high continuously → DONE pulses every 19 cycles; ERR_CNT is stable when patterns match.

Source files
------------

// File: rtl/scan_test_sequencer.sv
// Scan pattern applicator: shifts a stimulus into one mux-D scan chain, pulses a
// capture cycle, shifts the response out and compares it with an expected vector.
module scan_test_sequencer #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 CK,
  input  logic                 RESETN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT,
  output logic                 MISMATCH,
  output logic [CNT_W-1:0]     ERR_CNT
);

  localparam int             BW   = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [BW-1:0]  LAST = BW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [CHAIN_LEN-1:0] pat_sr_q, pat_sr_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] resp_sr_q, resp_sr_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHAIN_LEN-1:0] resp_out_q, resp_out_d;
  logic                 mismatch_q, mismatch_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [CHAIN_LEN-1:0] resp_next;

  assign resp_next = {resp_sr_q[CHAIN_LEN-2:0], SO};

  always_comb begin
    state_d    = state_q;
    pat_sr_d   = pat_sr_q;
    exp_d      = exp_q;
    resp_sr_d  = resp_sr_q;
    bit_cnt_d  = bit_cnt_q;
    se_d       = se_q;
    si_d       = si_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    resp_out_d = resp_out_q;
    mismatch_d = mismatch_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          // SI is registered, so the MSB goes out now and pat_sr holds the remainder.
          state_d    = LOAD;
          pat_sr_d   = {PAT_IN[CHAIN_LEN-2:0], 1'b0};
          si_d       = PAT_IN[CHAIN_LEN-1];
          exp_d      = EXP_IN;
          resp_sr_d  = '0;
          bit_cnt_d  = '0;
          se_d       = 1'b1;
          busy_d     = 1'b1;
          resp_out_d = '0;
          mismatch_d = 1'b0;
        end
      end
      LOAD: begin
        if (bit_cnt_q == LAST) begin
          state_d   = CAPTURE;
          bit_cnt_d = '0;
          se_d      = 1'b0;
          si_d      = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          si_d      = pat_sr_q[CHAIN_LEN-1];
          pat_sr_d  = {pat_sr_q[CHAIN_LEN-2:0], 1'b0};
        end
      end
      CAPTURE: begin
        state_d = UNLOAD;
        se_d    = 1'b1;
        si_d    = 1'b0;
      end
      UNLOAD: begin
        resp_sr_d = resp_next;
        if (bit_cnt_q == LAST) begin
          state_d    = FINISH;
          bit_cnt_d  = '0;
          se_d       = 1'b0;
          done_d     = 1'b1;
          resp_out_d = resp_next;
          mismatch_d = (resp_next != exp_q);
          if ((resp_next != exp_q) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        se_d    = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      pat_sr_q   <= '0;
      exp_q      <= '0;
      resp_sr_q  <= '0;
      bit_cnt_q  <= '0;
      se_q       <= 1'b0;
      si_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_out_q <= '0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pat_sr_q   <= pat_sr_d;
      exp_q      <= exp_d;
      resp_sr_q  <= resp_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      se_q       <= se_d;
      si_q       <= si_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      resp_out_q <= resp_out_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign SE       = se_q;
  assign SI       = si_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign RESP_OUT = resp_out_q;
  assign MISMATCH = mismatch_q;
  assign ERR_CNT  = err_cnt_q;

endmodule
